// File: rtl/input_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : input_pkg
//  Description : Shared constants and types for the arcade input hub:
//                joystick word bit indices, PS/2 set-2 scancodes, and the
//                active-low player/system byte layouts.
//  Revision    : 1.0 - initial release
// ============================================================================
package input_pkg;

    // Joystick word bit positions (one 16-bit word per player)
    localparam int JOY_R      = 0;
    localparam int JOY_L      = 1;
    localparam int JOY_D      = 2;
    localparam int JOY_U      = 3;
    localparam int JOY_T1     = 4;
    localparam int JOY_T2     = 5;
    localparam int JOY_T3     = 6;
    localparam int JOY_START1 = 7;
    localparam int JOY_START2 = 8;
    localparam int JOY_COIN   = 9;

    // PS/2 set-2 scancodes. Only the low byte is compared, so the E0
    // prefix bit never changes which key register an event lands in.
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;
    localparam logic [7:0] SC_SPACE = 8'h29;
    localparam logic [7:0] SC_CTRL  = 8'h14;
    localparam logic [7:0] SC_ALT   = 8'h11;
    localparam logic [7:0] SC_R     = 8'h2D;
    localparam logic [7:0] SC_F     = 8'h2B;
    localparam logic [7:0] SC_D     = 8'h23;
    localparam logic [7:0] SC_G     = 8'h34;
    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_S     = 8'h1B;
    localparam logic [7:0] SC_Q     = 8'h15;
    localparam logic [7:0] SC_1     = 8'h16;
    localparam logic [7:0] SC_2     = 8'h1E;
    localparam logic [7:0] SC_5     = 8'h2E;
    localparam logic [7:0] SC_6     = 8'h36;
    localparam logic [7:0] SC_F1    = 8'h05;
    localparam logic [7:0] SC_F2    = 8'h06;

    // Active-low player byte: {L,R,U,D,1,trig2,trig1,trig3}
    localparam int INP_T3  = 0;
    localparam int INP_T1  = 1;
    localparam int INP_T2  = 2;
    localparam int INP_ONE = 3;
    localparam int INP_D   = 4;
    localparam int INP_U   = 5;
    localparam int INP_R   = 6;
    localparam int INP_L   = 7;

    // Active-low system byte: {1,1,start2,start1,1,1,1,coin}
    localparam int SYS_COIN   = 0;
    localparam int SYS_START1 = 4;
    localparam int SYS_START2 = 5;

    // Active-high control set of one player; btn[0] is trig1.
    typedef struct packed {
        logic       up;
        logic       down;
        logic       left;
        logic       right;
        logic [2:0] btn;
    } player_ctl_t;

    // Everything the keyboard can hold down.
    typedef struct packed {
        player_ctl_t p0;
        player_ctl_t p1;
        logic        start1;
        logic        start2;
        logic        coin1;
        logic        coin2;
        logic        f1;
        logic        f2;
    } key_state_t;

    function automatic logic [7:0] pack_inp_n(input player_ctl_t c);
        logic [7:0] b;
        b          = '0;
        b[INP_L]   = c.left;
        b[INP_R]   = c.right;
        b[INP_U]   = c.up;
        b[INP_D]   = c.down;
        b[INP_T2]  = c.btn[1];
        b[INP_T1]  = c.btn[0];
        b[INP_T3]  = c.btn[2];
        return ~b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/arcade_input_hub_if.sv
`default_nettype none
// ============================================================================
//  Module      : arcade_input_hub_if
//  Description : Download (ioctl) write bus from hps_io into the input hub.
//                master = hps_io side (drives), slave = hub side (samples).
//  Ports       : ioctl_wr    write strobe
//                ioctl_index download index
//                ioctl_addr  byte address
//                ioctl_dout  byte data
//  Revision    : 1.0 - initial release
// ============================================================================
interface arcade_input_hub_if;
    logic        ioctl_wr;
    logic [7:0]  ioctl_index;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;

    modport master (output ioctl_wr, output ioctl_index, output ioctl_addr, output ioctl_dout);
    modport slave  (input  ioctl_wr, input  ioctl_index, input  ioctl_addr, input  ioctl_dout);
endinterface
`default_nettype wire

// File: rtl/input_pulse_stretch.sv
`default_nettype none
// ============================================================================
//  Module      : input_pulse_stretch
//  Description : Guarantees a minimum active width of HOLD cycles measured
//                from each rising edge of i_pulse. The output follows the
//                input combinationally, so assertion adds no latency.
//  Ports       : clk         clock
//                rst_n       async active-low reset
//                i_pulse     raw active-high input
//                o_stretched i_pulse OR (hold counter nonzero)
//  Revision    : 1.0 - initial release
// ============================================================================
module input_pulse_stretch #(
    parameter int HOLD = 480000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_pulse,
    output logic o_stretched
);

    localparam int            CW     = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [CW-1:0] C_LOAD = CW'(HOLD - 1);

    logic          pulse_q, pulse_d;
    logic [CW-1:0] cnt_q,   cnt_d;

    always_comb begin
        pulse_d = i_pulse;
        cnt_d   = cnt_q;
        // A fresh edge restarts the window even if one is still running.
        if (i_pulse && !pulse_q) begin
            cnt_d = C_LOAD;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pulse_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            pulse_q <= pulse_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_stretched = i_pulse | (cnt_q != '0);

endmodule
`default_nettype wire

// File: rtl/arcade_input_hub.sv
`default_nettype none
// ============================================================================
//  Module      : arcade_input_hub
//  Description : Player-input and DIP-switch front end. Merges joystick words
//                and PS/2 key events into active-low player bytes and a
//                system byte, with coin stretching, frame-locked autofire
//                and a DIP byte bank loaded over the download bus.
//  Ports       : clk_sys, reset_n      clock, async active-low reset
//                ps2_key[10:0]         {toggle, pressed, scancode[8:0]}
//                joy                   16 bits per player
//                cabinet               0 upright (P1 OR-ed into P0), 1 cocktail
//                af_en                 per-button autofire enable
//                vblank                frame marker
//                dl                    download bus (slave modport)
//                inp_n                 8 bits per player, active low
//                sys_n                 {1,1,start2,start1,1,1,1,coin}, active low
//                dsw                   DSW_DEPTH DIP bytes
//  Revision    : 1.0 - initial release
// ============================================================================
module arcade_input_hub
    import input_pkg::*;
#(
    parameter int NPLAYERS  = 2,
    parameter int NBUTTONS  = 3,
    parameter int COIN_HOLD = 480000,
    parameter int AF_FRAMES = 2,
    parameter int DSW_DEPTH = 8,
    parameter int DSW_INDEX = 254
) (
    input  logic                         clk_sys,
    input  logic                         reset_n,
    input  logic [10:0]                  ps2_key,
    input  logic [NPLAYERS*16-1:0]       joy,
    input  logic                         cabinet,
    input  logic [NPLAYERS*NBUTTONS-1:0] af_en,
    input  logic                         vblank,
    arcade_input_hub_if.slave            dl,
    output logic [NPLAYERS*8-1:0]        inp_n,
    output logic [7:0]                   sys_n,
    output logic [DSW_DEPTH*8-1:0]       dsw
);

    localparam logic [2:0] C_BTN_MASK = 3'((1 << NBUTTONS) - 1);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic                   tog_q,    tog_d;
    key_state_t             key_q,    key_d;
    logic                   vblank_q, vblank_d;
    logic [3:0]             frame_q,  frame_d;
    logic                   phase_q,  phase_d;
    logic [NPLAYERS*8-1:0]  inp_n_q,  inp_n_d;
    logic [7:0]             sys_n_q,  sys_n_d;
    logic [DSW_DEPTH*8-1:0] dsw_q,    dsw_d;

    // ------------------------------------------------------------------
    // Keyboard decode: one update per edge of the event toggle bit
    // ------------------------------------------------------------------
    always_comb begin
        key_d = key_q;
        tog_d = ps2_key[10];
        if (ps2_key[10] != tog_q) begin
            case (ps2_key[7:0])
                SC_UP:    key_d.p0.up     = ps2_key[9];
                SC_DOWN:  key_d.p0.down   = ps2_key[9];
                SC_LEFT:  key_d.p0.left   = ps2_key[9];
                SC_RIGHT: key_d.p0.right  = ps2_key[9];
                SC_SPACE: key_d.p0.btn[0] = ps2_key[9];
                SC_CTRL:  key_d.p0.btn[1] = ps2_key[9];
                SC_ALT:   key_d.p0.btn[2] = ps2_key[9];
                SC_R:     key_d.p1.up     = ps2_key[9];
                SC_F:     key_d.p1.down   = ps2_key[9];
                SC_D:     key_d.p1.left   = ps2_key[9];
                SC_G:     key_d.p1.right  = ps2_key[9];
                SC_A:     key_d.p1.btn[0] = ps2_key[9];
                SC_S:     key_d.p1.btn[1] = ps2_key[9];
                SC_Q:     key_d.p1.btn[2] = ps2_key[9];
                SC_1:     key_d.start1    = ps2_key[9];
                SC_2:     key_d.start2    = ps2_key[9];
                SC_5:     key_d.coin1     = ps2_key[9];
                SC_6:     key_d.coin2     = ps2_key[9];
                SC_F1:    key_d.f1        = ps2_key[9];
                SC_F2:    key_d.f2        = ps2_key[9];
                default:  ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Autofire phase: toggles every AF_FRAMES vblank rising edges
    // ------------------------------------------------------------------
    always_comb begin
        vblank_d = vblank;
        frame_d  = frame_q;
        phase_d  = phase_q;
        if (vblank && !vblank_q) begin
            if (frame_q == 4'(AF_FRAMES - 1)) begin
                frame_d = 4'd0;
                phase_d = ~phase_q;
            end else begin
                frame_d = frame_q + 4'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-player merge and button gating
    // ------------------------------------------------------------------
    player_ctl_t w_raw [NPLAYERS];
    player_ctl_t w_eff [NPLAYERS];
    player_ctl_t w_p1_raw;

    generate
        if (NPLAYERS > 1) begin : g_cab
            assign w_p1_raw = w_raw[1];
        end else begin : g_no_cab
            assign w_p1_raw = '0;
        end
    endgenerate

    generate
        for (genvar p = 0; p < NPLAYERS; p++) begin : g_player
            player_ctl_t w_kb;
            player_ctl_t w_mrg;
            logic [2:0]  w_af;
            logic [2:0]  w_gate;

            if (p == 0) begin : g_kb0
                assign w_kb = key_q.p0;
            end else if (p == 1) begin : g_kb1
                assign w_kb = key_q.p1;
            end else begin : g_kbn
                assign w_kb = '0;
            end

            assign w_raw[p] = player_ctl_t'({joy[16*p+JOY_U],  joy[16*p+JOY_D],
                                             joy[16*p+JOY_L],  joy[16*p+JOY_R],
                                             joy[16*p+JOY_T3], joy[16*p+JOY_T2],
                                             joy[16*p+JOY_T1]}) | w_kb;

            // Upright cabinet: both control sets drive player 0.
            if (p == 0) begin : g_mrg0
                assign w_mrg = cabinet ? w_raw[0] : player_ctl_t'(w_raw[0] | w_p1_raw);
            end else begin : g_mrgn
                assign w_mrg = w_raw[p];
            end

            for (genvar b = 0; b < 3; b++) begin : g_btn
                if (b < NBUTTONS) begin : g_af_on
                    assign w_af[b] = af_en[p*NBUTTONS+b];
                end else begin : g_af_off
                    assign w_af[b] = 1'b0;
                end
                assign w_gate[b] = w_af[b] ? phase_q : 1'b1;
            end

            assign w_eff[p] = player_ctl_t'({w_mrg.up, w_mrg.down, w_mrg.left, w_mrg.right,
                                             w_mrg.btn & w_gate & C_BTN_MASK});
        end
    endgenerate

    // ------------------------------------------------------------------
    // Start / coin sources and coin stretcher
    // ------------------------------------------------------------------
    logic w_start1, w_start2, w_coin_raw, w_coin_out;
    logic w_unused;

    always_comb begin
        w_start1   = key_q.start1 | key_q.f1;
        w_start2   = key_q.start2 | key_q.f2;
        w_coin_raw = key_q.coin1 | key_q.coin2 | key_q.f1 | key_q.f2;
        // E0 prefix and spare joystick bits carry nothing for this hub.
        w_unused   = ps2_key[8];
        for (int p = 0; p < NPLAYERS; p++) begin
            w_start1   = w_start1   | joy[16*p+JOY_START1];
            w_start2   = w_start2   | joy[16*p+JOY_START2];
            w_coin_raw = w_coin_raw | joy[16*p+JOY_COIN];
            w_unused   = w_unused   ^ (^joy[16*p+10 +: 6]);
        end
    end

    input_pulse_stretch #(
        .HOLD        (COIN_HOLD)
    ) u_coin_stretch (
        .clk         (clk_sys),
        .rst_n       (reset_n),
        .i_pulse     (w_coin_raw),
        .o_stretched (w_coin_out)
    );

    // ------------------------------------------------------------------
    // Output bytes and DIP bank
    // ------------------------------------------------------------------
    always_comb begin
        inp_n_d = '1;
        for (int p = 0; p < NPLAYERS; p++) begin
            inp_n_d[8*p +: 8] = pack_inp_n(w_eff[p]);
        end
        sys_n_d             = 8'hFF;
        sys_n_d[SYS_COIN]   = ~w_coin_out;
        sys_n_d[SYS_START1] = ~w_start1;
        sys_n_d[SYS_START2] = ~w_start2;
    end

    always_comb begin
        dsw_d = dsw_q;
        if (dl.ioctl_wr && (dl.ioctl_index == 8'(DSW_INDEX)) &&
            (dl.ioctl_addr < 25'(DSW_DEPTH))) begin
            for (int k = 0; k < DSW_DEPTH; k++) begin
                if (dl.ioctl_addr == 25'(k)) begin
                    dsw_d[8*k +: 8] = dl.ioctl_dout;
                end
            end
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            tog_q    <= 1'b0;
            key_q    <= '0;
            vblank_q <= 1'b0;
            frame_q  <= 4'd0;
            phase_q  <= 1'b1;
            inp_n_q  <= '1;
            sys_n_q  <= 8'hFF;
            dsw_q    <= '1;
        end else begin
            tog_q    <= tog_d;
            key_q    <= key_d;
            vblank_q <= vblank_d;
            frame_q  <= frame_d;
            phase_q  <= phase_d;
            inp_n_q  <= inp_n_d;
            sys_n_q  <= sys_n_d;
            dsw_q    <= dsw_d;
        end
    end

    assign inp_n = inp_n_q;
    assign sys_n = sys_n_q;
    assign dsw   = dsw_q;

endmodule
`default_nettype wire

// File: tb/tb_arcade_input_hub.sv
`default_nettype none
// ============================================================================
//  Module      : tb_arcade_input_hub
//  Description : Self-checking bench for arcade_input_hub. Directed sequences
//                followed by randomized traffic, all compared each cycle
//                against a behavioural model of the hub.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_arcade_input_hub;

    localparam int NP   = 2;
    localparam int NB   = 3;
    localparam int HOLD = 10;
    localparam int AFF  = 2;
    localparam int DEP  = 8;
    localparam int DIDX = 254;

    logic            clk_sys = 1'b0;
    logic            reset_n = 1'b0;
    logic [10:0]     ps2_key = '0;
    logic [NP*16-1:0] joy    = '0;
    logic            cabinet = 1'b1;
    logic [NP*NB-1:0] af_en  = '0;
    logic            vblank  = 1'b0;
    logic [NP*8-1:0] inp_n;
    logic [7:0]      sys_n;
    logic [DEP*8-1:0] dsw;

    arcade_input_hub_if dl_if ();

    arcade_input_hub #(
        .NPLAYERS  (NP),
        .NBUTTONS  (NB),
        .COIN_HOLD (HOLD),
        .AF_FRAMES (AFF),
        .DSW_DEPTH (DEP),
        .DSW_INDEX (DIDX)
    ) dut (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .ps2_key (ps2_key),
        .joy     (joy),
        .cabinet (cabinet),
        .af_en   (af_en),
        .vblank  (vblank),
        .dl      (dl_if),
        .inp_n   (inp_n),
        .sys_n   (sys_n),
        .dsw     (dsw)
    );

    always #5 clk_sys = ~clk_sys;

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // ---------------------------- reference model ----------------------
    bit         kd [256];      // key currently held, indexed by scancode low byte
    bit         last_tog;
    int         cyc;
    int         coin_rise;
    bit         coin_prev;
    int         vb_edges;
    bit         vb_prev;
    logic [7:0] dsw_m [DEP];
    logic [15:0] exp_inp;
    logic [7:0]  exp_sys;
    logic [63:0] exp_dsw;

    task automatic model_reset();
        for (int i = 0; i < 256; i++) kd[i] = 1'b0;
        last_tog  = 1'b0;
        coin_prev = 1'b0;
        coin_rise = cyc - 1000;
        vb_edges  = 0;
        vb_prev   = 1'b0;
        for (int i = 0; i < DEP; i++) dsw_m[i] = 8'hFF;
    endtask

    // Expected outputs after the coming clock edge, then advance state.
    task automatic model_edge();
        bit up[NP], dn[NP], lf[NP], rt[NP];
        bit tr[NP][3];
        bit phase, s1, s2, craw, coin;
        for (int p = 0; p < NP; p++) begin
            up[p] = joy[16*p+3]; dn[p] = joy[16*p+2];
            lf[p] = joy[16*p+1]; rt[p] = joy[16*p+0];
            for (int b = 0; b < 3; b++) tr[p][b] = joy[16*p+4+b];
        end
        up[0] |= kd['h75]; dn[0] |= kd['h72]; lf[0] |= kd['h6B]; rt[0] |= kd['h74];
        tr[0][0] |= kd['h29]; tr[0][1] |= kd['h14]; tr[0][2] |= kd['h11];
        up[1] |= kd['h2D]; dn[1] |= kd['h2B]; lf[1] |= kd['h23]; rt[1] |= kd['h34];
        tr[1][0] |= kd['h1C]; tr[1][1] |= kd['h1B]; tr[1][2] |= kd['h15];
        if (!cabinet) begin
            up[0] |= up[1]; dn[0] |= dn[1]; lf[0] |= lf[1]; rt[0] |= rt[1];
            for (int b = 0; b < 3; b++) tr[0][b] |= tr[1][b];
        end
        phase = ((vb_edges / AFF) % 2) == 0;
        for (int p = 0; p < NP; p++) begin
            for (int b = 0; b < 3; b++) if (af_en[p*NB+b]) tr[p][b] &= phase;
            exp_inp[8*p +: 8] = ~{lf[p], rt[p], up[p], dn[p], 1'b0, tr[p][1], tr[p][0], tr[p][2]};
        end
        s1   = joy[7] | joy[23] | kd['h16] | kd['h05];
        s2   = joy[8] | joy[24] | kd['h1E] | kd['h06];
        craw = joy[9] | joy[25] | kd['h2E] | kd['h36] | kd['h05] | kd['h06];
        if (craw && !coin_prev) coin_rise = cyc;
        coin_prev = craw;
        coin = craw || ((cyc - coin_rise) < HOLD);
        exp_sys = ~{2'b00, s2, s1, 3'b000, coin};
        if (vblank && !vb_prev) vb_edges++;
        vb_prev = vblank;
        if (ps2_key[10] != last_tog) begin
            kd[ps2_key[7:0]] = ps2_key[9];
            last_tog = ps2_key[10];
        end
        if (dl_if.ioctl_wr && dl_if.ioctl_index == 8'(DIDX) && dl_if.ioctl_addr < 25'(DEP))
            dsw_m[dl_if.ioctl_addr[2:0]] = dl_if.ioctl_dout;
        for (int i = 0; i < DEP; i++) exp_dsw[8*i +: 8] = dsw_m[i];
        cyc++;
    endtask

    task automatic step();
        model_edge();
        @(posedge clk_sys);
        #1;
        chk("inp_n", 64'(inp_n), 64'(exp_inp));
        chk("sys_n", 64'(sys_n), 64'(exp_sys));
        chk("dsw",   dsw,        exp_dsw);
    endtask

    task automatic ps2_event(input logic pressed, input logic [8:0] code);
        ps2_key = {~ps2_key[10], pressed, code};
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_inp"}, 64'(inp_n), 64'hFFFF);
        chk({tag, "_sys"}, 64'(sys_n), 64'hFF);
        chk({tag, "_dsw"}, dsw, 64'hFFFF_FFFF_FFFF_FFFF);
    endtask

    logic [7:0] codes [24] = '{8'h75, 8'h72, 8'h6B, 8'h74, 8'h29, 8'h14, 8'h11, 8'h2D,
                               8'h2B, 8'h23, 8'h34, 8'h1C, 8'h1B, 8'h15, 8'h16, 8'h1E,
                               8'h2E, 8'h36, 8'h05, 8'h06, 8'h4A, 8'h00, 8'h5A, 8'h76};

    initial begin
        dl_if.ioctl_wr    = 1'b0;
        dl_if.ioctl_index = '0;
        dl_if.ioctl_addr  = '0;
        dl_if.ioctl_dout  = '0;
        cyc = 0;
        model_reset();

        repeat (3) @(posedge clk_sys);
        #1;
        check_reset_state("reset");
        reset_n = 1'b1;

        // P0 up from the joystick: one cycle to the output
        joy[3] = 1'b1;
        step();
        chk("p0_up_bit", 64'(inp_n[5]), 64'd0);
        joy[3] = 1'b0;
        step();

        // Keyboard: space press, repeated value, release
        ps2_event(1'b1, 9'h029);
        step(); step();
        chk("kb_space_bit", 64'(inp_n[1]), 64'd0);
        ps2_key[8] = 1'b1;                 // no toggle change: must not decode
        step(); step();
        ps2_event(1'b0, 9'h029);
        step(); step();

        // Upright vs cocktail with P1 trig1
        cabinet = 1'b0; joy[20] = 1'b1;
        step();
        cabinet = 1'b1;
        step();
        joy[20] = 1'b0;
        step();

        // Coin stretch: single pulse, then a retrigger at cycle 5
        joy[9] = 1'b1; step(); joy[9] = 1'b0;
        repeat (13) step();
        joy[9] = 1'b1; step(); joy[9] = 1'b0;
        repeat (4) step();
        joy[9] = 1'b1; step(); joy[9] = 1'b0;
        repeat (16) step();

        // Autofire on P0 trig1 over 8 frames
        af_en[0] = 1'b1; joy[4] = 1'b1;
        for (int f = 0; f < 8; f++) begin
            vblank = 1'b1; step();
            vblank = 1'b0; step(); step();
        end
        af_en[0] = 1'b0; joy[4] = 1'b0;
        step();

        // DIP loader: in-range, out-of-range, and wrong index
        dl_if.ioctl_wr    = 1'b1;
        dl_if.ioctl_index = 8'd254;
        for (int a = 0; a < 10; a++) begin
            dl_if.ioctl_addr = 25'(a);
            dl_if.ioctl_dout = 8'hA0 + 8'(a);
            step();
        end
        dl_if.ioctl_index = 8'd1;
        for (int a = 0; a < 4; a++) begin
            dl_if.ioctl_addr = 25'(a);
            dl_if.ioctl_dout = 8'h55;
            step();
        end
        dl_if.ioctl_wr = 1'b0;
        step();

        // Randomized traffic with an asynchronous reset in the middle
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                #2 reset_n = 1'b0;
                #1;
                check_reset_state("midreset");
                model_reset();
                @(posedge clk_sys);
                #1;
                check_reset_state("midreset_hold");
                reset_n = 1'b1;
            end
            if ($urandom_range(0, 3) == 0) begin
                for (int j = 0; j < NP*16; j++) joy[j] = ($urandom_range(0, 7) == 0);
            end
            joy[9]  = ($urandom_range(0, 29) == 0);
            joy[25] = ($urandom_range(0, 29) == 0);
            vblank  = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 49) == 0) cabinet = ~cabinet;
            if ($urandom_range(0, 39) == 0) af_en = NP*NB'($urandom);
            if ($urandom_range(0, 4) == 0)
                ps2_event(1'($urandom), {1'($urandom), codes[$urandom_range(0, 23)]});
            else if ($urandom_range(0, 4) == 0)
                ps2_key[9:0] = 10'($urandom);
            dl_if.ioctl_wr    = ($urandom_range(0, 3) == 0);
            dl_if.ioctl_index = ($urandom_range(0, 1) == 0) ? 8'd254 : 8'($urandom);
            dl_if.ioctl_addr  = 25'($urandom_range(0, 11));
            dl_if.ioctl_dout  = 8'($urandom);
            step();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/arcade_input_hub.md
Name: arcade_input_hub

Overview:
- Parametrised player-input and DIP-switch front end for arcade cores. Sits between hps_io and the game core.
- Merges USB/DB15 joystick words and PS/2 keyboard events into per-player active-low input bytes and one system byte (starts/coin).
- Adds behaviour the per-core input glue lacks: N players, coin pulse stretching, frame-locked autofire, and a depth-parametrised DIP bank loader.

Parameters:
- NPLAYERS, 2, number of player input bytes (1..4); keyboard maps only players 0 and 1.
- NBUTTONS, 3, fire buttons per player (1..3); unused button bits are forced inactive.
- COIN_HOLD, 480000, minimum coin-active width in clk_sys cycles (10 ms at 48 MHz).
- AF_FRAMES, 2, vblank rising edges per autofire phase toggle (1..15).
- DSW_DEPTH, 8, number of DIP bytes held.
- DSW_INDEX, 254, ioctl_index value that selects DIP data.

Ports:
- clk_sys  in  1  system clock.
- reset_n  in  1  async active-low reset.
- ps2_key  in  11  [10] event toggle, [9] pressed, [8:0] scancode (E0-extended in [8]).
- joy  in  NPLAYERS*16  per-player joystick word. Bits: [0]R [1]L [2]D [3]U [4..6] trig1..3 [7] start1 [8] start2 [9] coin.
- cabinet  in  1  0 = upright (player 1 controls OR-ed into player 0); 1 = cocktail, separate players.
- af_en  in  NPLAYERS*NBUTTONS  per-button autofire enable.
- vblank  in  1  frame marker, synchronous to clk_sys.
- ioctl_wr  in  1  download write strobe.
- ioctl_index  in  8  download index.
- ioctl_addr  in  25  download address.
- ioctl_dout  in  8  download data.
- inp_n  out  NPLAYERS*8  per-player byte, active low: {L,R,U,D,1,trig2,trig1,trig3}.
- sys_n  out  8  active low: {1,1,start2,start1,1,1,1,coin}.
- dsw  out  DSW_DEPTH*8  DIP bytes; byte k occupies bits [8k+7:8k].

Behaviour:
- Reset values: inp_n all ones, sys_n 8'hFF, dsw all ones, keyboard state 0, coin counter 0, autofire phase 1, frame counter 0.
- Keyboard decode:
  - On a change of ps2_key[10] versus its registered copy, the matching key register loads ps2_key[9]. Exactly one decode per toggle.
  - Arrow keys (E0 75/72/6B/74; [8] don't-care) map to P0 directions; space/ctrl/alt map to P0 trig1/2/3.
  - R/F/D/G map to P1 directions; A/S/Q map to P1 trig1/2/3.
  - 1/2 map to start1/start2; 5/6 map to coin1/coin2.
  - F1 and F2 each assert start and coin.
  - Unmapped codes are ignored.
- Merge: raw = joystick bit OR key bit. When cabinet=0, player 1 raw bits are also OR-ed into player 0; player 1 outputs remain driven.
- Start: start1/start2 are the OR over all players' joy bits plus keys.
- Autofire:
  - Detect the vblank rising edge. The frame counter counts edges; at AF_FRAMES-1 it wraps to 0 and the autofire phase toggles.
  - Effective button = raw & (af_en ? phase : 1). Phase is global.
- Coin stretcher:
  - coin_raw = OR of every coin source.
  - A rising edge of coin_raw loads the counter with COIN_HOLD-1. The counter then decrements to 0; it is reloaded on a new edge even if nonzero.
  - coin_out = coin_raw | (counter != 0).
- Output registers: inp_n and sys_n are registered, giving 1-cycle latency from joy/key register to output. Coin adds no extra latency on assertion.
- DIP loader: if ioctl_wr, ioctl_index==DSW_INDEX and ioctl_addr < DSW_DEPTH, then dsw byte[addr] <= ioctl_dout. Writes at or beyond DSW_DEPTH are dropped. Last write wins.
- Reset mid-operation: all state clears asynchronously; outputs return to all ones immediately.

Decomposition:
- Shared package input_pkg: joystick bit-index constants; scancode constants; the active-low byte layout as localparams.
- One sub-module: input_pulse_stretch, a parametrised width counter. Used for coin; reusable for service inputs.

Test Plan:
- Reset → inp_n=16'hFFFF, sys_n=8'hFF, dsw all 8'hFF. Release, joy[3]=1 (P0 up) → inp_n[5]=0 after 1 cycle.
- PS/2 toggle with code 'h029 pressed → P0 trig1 bit [1]=0. Repeat the same toggle value with no change → no new decode. Toggle with pressed=0 → bit back to 1.
- cabinet=0, joy P1 bit4 → inp_n[1]=0 and inp_n[9]=0. cabinet=1 → only inp_n[9]=0.
- joy coin pulse of 1 cycle, COIN_HOLD=10 → sys_n[0]=0 for exactly 10 cycles. Second edge at cycle 5 → low until cycle 15.
- af_en[0]=1, AF_FRAMES=2, trig1 held, 8 vblank pulses → inp_n[1] alternates every 2 frames.
- ioctl_index=254, addr 0..9 with data A0..A9, DSW_DEPTH=8 → dsw bytes 0..7 = A0..A7; addr 8/9 dropped. Index 1 writes → no change.
